mux2_sel: RTL and testbench

Two-input, parameter-width selector: output `y` follows input `a` when `sel` is 0 and input `b` when `sel` is 1. The block serves as the basic steering primitive in the datapath. It provides a zero-latency combinational output for glue logic and a one-cycle registered copy, with a valid flag, for timing-closed paths. A saturating counter of select changes supports debug and coverage.

---
 rtl/mux2_sel.sv | 73 +++++++
 tb/tb_mux2_sel.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux2_sel.sv
// mux2_sel: two-input WIDTH-bit selector with a zero-latency output, a one-cycle
// registered copy qualified by out_valid, and a saturating count of select changes.
module mux2_sel #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             sel_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] w_mux;
  logic             w_sel_changed;
  logic             w_cnt_full;

  logic [WIDTH-1:0] r_y_q;
  logic             r_sel_q;
  logic             r_out_valid;
  logic             r_sel_prev;
  logic [CNT_W-1:0] r_toggle_cnt;

  assign w_mux         = sel ? b : a;
  assign w_sel_changed = sel ^ r_sel_prev;
  assign w_cnt_full    = &r_toggle_cnt;

  // Registered copy of the mux result; data and select hold while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q       <= '0;
      r_sel_q     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y_q   <= w_mux;
        r_sel_q <= sel;
      end else begin
        r_y_q   <= r_y_q;
        r_sel_q <= r_sel_q;
      end
    end
  end

  // Select-change counter; sel_prev clears to 0 so a high sel after reset counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_prev   <= 1'b0;
      r_toggle_cnt <= '0;
    end else begin
      r_sel_prev <= sel;
      if (w_sel_changed && !w_cnt_full) begin
        r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
      end else begin
        r_toggle_cnt <= r_toggle_cnt;
      end
    end
  end

  assign y          = w_mux;
  assign y_q        = r_y_q;
  assign out_valid  = r_out_valid;
  assign sel_q      = r_sel_q;
  assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_mux2_sel.sv
// Bench for mux2_sel: a 1-bit/2-bit-counter instance for truth table, reset and
// saturation corners, and an 8-bit instance exercised randomly against a model.
module tb_mux2_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a1, b1, sel1, iv1;
  logic       y1, yq1, ov1, selq1;
  logic [1:0] cnt1;

  logic [7:0] a8, b8;
  logic       sel8, iv8;
  logic [7:0] y8, yq8;
  logic       ov8, selq8;
  logic [7:0] cnt8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux2_sel #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .in_valid(iv1),
    .y(y1), .y_q(yq1), .out_valid(ov1), .sel_q(selq1), .toggle_cnt(cnt1)
  );

  mux2_sel #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .in_valid(iv8),
    .y(y8), .y_q(yq8), .out_valid(ov8), .sel_q(selq8), .toggle_cnt(cnt8)
  );

  // Reference model for the 8-bit instance: last accepted transaction plus an
  // unbounded count of select changes, clipped to the counter range when compared.
  logic [7:0] m_yq;
  logic       m_selq, m_ov, m_prev;
  int         m_tog;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq <= 8'h00; m_selq <= 1'b0; m_ov <= 1'b0; m_prev <= 1'b0; m_tog <= 0;
    end else begin
      m_ov <= iv8;
      if (iv8) begin
        m_yq   <= sel8 ? b8 : a8;
        m_selq <= sel8;
      end
      if (sel8 != m_prev) m_tog <= m_tog + 1;
      m_prev <= sel8;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic y;
  } vec_t;

  vec_t tt[8];
  int   sat_exp[5];

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
    sat_exp = '{1, 2, 3, 3, 3};

    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0; iv1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0; iv8 = 1'b0;

    // Reset state
    #1;
    chk("rst_yq1", yq1, 0);   chk("rst_ov1", ov1, 0);
    chk("rst_selq1", selq1, 0); chk("rst_cnt1", cnt1, 0);
    chk("rst_yq8", yq8, 0);   chk("rst_ov8", ov8, 0);
    chk("rst_cnt8", cnt8, 0);

    // Combinational truth table, applied while still in reset
    for (int i = 0; i < 8; i++) begin
      a1 = tt[i].a; b1 = tt[i].b; sel1 = tt[i].sel;
      #1;
      chk($sformatf("tt%0d_y", i), y1, tt[i].y);
      #9;
    end

    // Release reset
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0; iv1 = 1'b0;
    rst_n = 1'b1;

    // Registered path: capture, then hold with in_valid low
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    chk("reg_yq", yq1, 1); chk("reg_selq", selq1, 0); chk("reg_ov", ov1, 1);
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1; sel1 = 1'b1;
    @(posedge clk); #1;
    chk("hold_yq", yq1, 1); chk("hold_selq", selq1, 0); chk("hold_ov", ov1, 0);
    chk("hold_cnt", cnt1, 1);

    // Asynchronous reset between edges
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    chk("pre_yq", yq1, 1); chk("pre_ov", ov1, 1); chk("pre_cnt", cnt1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_yq", yq1, 0); chk("arst_ov", ov1, 0);
    chk("arst_selq", selq1, 0); chk("arst_cnt", cnt1, 0);
    chk("arst_y_a", y1, 1);
    chk("arst_ov8", ov8, 0);
    sel1 = 1'b1; iv1 = 1'b0;
    #1;
    chk("arst_y_b", y1, 0);

    // Toggle saturation from reset release with sel high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sel1 = (i % 2 == 0);
      if (i == 0) rst_n = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("sat%0d_cnt", i), cnt1, sat_exp[i]);
    end

    // Wide data, directed
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0; iv8 = 1'b1;
    #1 chk("wide_y_a", y8, 8'hA5);
    @(posedge clk); #1;
    chk("wide_yq_a", yq8, 8'hA5); chk("wide_selq_a", selq8, 0); chk("wide_ov", ov8, 1);
    @(negedge clk);
    sel8 = 1'b1;
    #1 chk("wide_y_b", y8, 8'h3C);
    @(posedge clk); #1;
    chk("wide_yq_b", yq8, 8'h3C); chk("wide_selq_b", selq8, 1);

    // Randomized run against the model, with one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      sel8 = 1'($urandom); iv8 = ($urandom_range(0, 3) != 0);
      #1 chk("rnd_y", y8, sel8 ? b8 : a8);
      @(posedge clk); #1;
      chk("rnd_yq", yq8, m_yq); chk("rnd_selq", selq8, m_selq);
      chk("rnd_ov", ov8, m_ov);
      chk("rnd_cnt", cnt8, (m_tog > 255) ? 255 : m_tog);
      if (c == 300) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rnd_arst_yq", yq8, 0); chk("rnd_arst_ov", ov8, 0);
        chk("rnd_arst_cnt", cnt8, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
